uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8-bit UART receiver: 16x oversampling, mid-bit sampling, framing/parity pulses.
// Build with UART_RX_PARITY_EN defined to add one even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int CLK_FREQ = 18432000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_error,
  output logic       parity_error,
  output logic       busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;
`endif

  state_t           r_state, w_state;
  logic             r_meta, w_meta;
  logic             r_rxs, w_rxs;
  logic [DIV_W-1:0] r_div, w_div;
  logic [3:0]       r_tick, w_tick_cnt;
  logic [2:0]       r_bit, w_bit;
  logic [7:0]       r_shift, w_shift;
  logic [7:0]       r_data, w_data;
  logic             r_dv, w_dv;
  logic             r_ferr, w_ferr;
  logic             r_perr, w_perr;
  logic             w_tick;
  logic             w_samp;
`ifdef UART_RX_PARITY_EN
  logic             r_par, w_par;
`endif

  assign w_tick = (r_div == DIV_W'(DIV - 1));
  // Bit centres fall every 16 ticks once the start bit centre has been found.
  assign w_samp = w_tick && (r_tick == 4'd15);

  always_comb begin
    w_state    = r_state;
    w_meta     = r_meta;
    w_rxs      = r_rxs;
    w_div      = r_div;
    w_tick_cnt = r_tick;
    w_bit      = r_bit;
    w_shift    = r_shift;
    w_data     = r_data;
    w_dv       = 1'b0;
    w_ferr     = 1'b0;
    w_perr     = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par      = r_par;
`endif
    if (ce) begin
      w_meta = rx;
      w_rxs  = r_meta;
      if (r_state != S_IDLE) begin
        w_div = w_tick ? '0 : r_div + 1'b1;
        if (w_tick) w_tick_cnt = r_tick + 4'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (!r_rxs) begin
            w_state    = S_START;
            w_div      = '0;
            w_tick_cnt = 4'd0;
          end
        end
        S_START: begin
          if (w_tick && (r_tick == 4'd7)) begin
            if (r_rxs) begin
              w_state = S_IDLE;
            end else begin
              w_state    = S_DATA;
              w_tick_cnt = 4'd0;
              w_bit      = 3'd0;
            end
          end
        end
        S_DATA: begin
          if (w_samp) begin
            w_shift = {r_rxs, r_shift[7:1]};
            w_bit   = r_bit + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (r_bit == 3'd7) w_state = S_PARITY;
`else
            if (r_bit == 3'd7) w_state = S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_samp) begin
            w_par   = r_rxs;
            w_state = S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (w_samp) begin
`ifdef UART_RX_PARITY_EN
            w_perr = (r_par != ^r_shift);
`endif
            if (r_rxs) begin
              if (!w_perr) begin
                w_data = r_shift;
                w_dv   = 1'b1;
              end
              w_state = S_IDLE;
            end else begin
              w_ferr  = 1'b1;
              w_state = S_WAIT_HIGH;
            end
          end
        end
        S_WAIT_HIGH: begin
          if (r_rxs) w_state = S_IDLE;
        end
        default: w_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_meta  <= 1'b1;
      r_rxs   <= 1'b1;
      r_div   <= '0;
      r_tick  <= 4'd0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
      r_data  <= 8'h00;
      r_dv    <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state;
      r_meta  <= w_meta;
      r_rxs   <= w_rxs;
      r_div   <= w_div;
      r_tick  <= w_tick_cnt;
      r_bit   <= w_bit;
      r_shift <= w_shift;
      r_data  <= w_data;
      r_dv    <= w_dv;
      r_ferr  <= w_ferr;
      r_perr  <= w_perr;
`ifdef UART_RX_PARITY_EN
      r_par   <= w_par;
`endif
    end
  end

  assign data_out      = r_data;
  assign data_valid    = r_dv;
  assign framing_error = r_ferr;
  assign parity_error  = r_perr;
  assign busy          = (r_state != S_IDLE);

endmodule
